ex_mem_pipe_stage: RTL
======================

# ex_mem_pipe_stage

Parametrised, elastic pipeline register for the EX→MEM boundary of the RISC-V pipeline. It adds a valid/ready handshake, stall backpressure, flush-to-bubble and a stall-cycle counter. Control and data widths are configurable, and the payload is carried as a control vector, N data lanes and a destination-register index. An optional skid buffer breaks the combinational ready path for timing closure.

## Interface
Parameters:
- CTRL_W, 7: width of control vector (Reg_w, M_to_R, Mem_W, Mem_Rd, Jal, Branch, Jal_Alu in default build)
- DATA_W, 32: width of one data lane
- N_LANES, 5: number of data lanes (Inm_result, PC, PC_p4, Reg2, ALU_result in default build)
- RD_W, 5: destination register index width
- CNT_W, 16: stall counter width

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous squash of all held entries
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept an entry this cycle
- ctrl_i  in  CTRL_W  control vector
- data_i  in  N_LANES*DATA_W  lanes, lane k at bits [k*DATA_W +: DATA_W]
- rd_i  in  RD_W  destination register
- out_valid_o  out  1  held entry valid
- out_ready_i  in  1  downstream consumes entry this cycle
- ctrl_o  out  CTRL_W  control vector, forced 0 when out_valid_o=0
- data_o  out  N_LANES*DATA_W  held lanes
- rd_o  out  RD_W  destination register, forced 0 when out_valid_o=0
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles

## Operation
- Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
- Main register is written on an input transfer. With no input transfer and an output transfer, out_valid_o clears. Otherwise the register holds.
- A bubble (out_valid_o=0) presents ctrl_o=0 and rd_o=0, so no register write or memory access occurs downstream. data_o keeps its last value.
- Simultaneous input and output transfers replace the entry without a bubble.
- Flush: on the rising edge with flush_i=1, all valid bits clear, regardless of in_valid_i or out_ready_i. Flush overrides a same-cycle load. data_o is not cleared. in_ready_o is unaffected by flush_i.
- Stall counter:
  - Increments on each cycle with out_valid_o=1 and out_ready_i=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- Reset (asynchronous): out_valid_o=0, ctrl_o=0, rd_o=0, data_o=0, stall_cnt_o=0, skid entry invalid and zero.

## Timing
- Latency: 1 cycle from input transfer to out_valid_o=1 with that payload.
- Throughput: 1 entry/cycle when out_ready_i is held high.
- in_ready_o must not depend on in_valid_i.
- Reset deassertion: the first transfer is accepted on the first rising edge after reset_i falls.

## Configuration
- PIPE_SKID_EN undefined:
  - Single entry.
  - in_ready_o = !out_valid_o | out_ready_i (combinational from out_ready_i).
- PIPE_SKID_EN defined:
  - Two entries: main plus skid.
  - in_ready_o = !skid_valid, registered, with no combinational path from out_ready_i.
  - An input accepted while main is valid and out_ready_i=0 goes to skid.
  - On the next output transfer, skid moves into main.
  - Order is strictly FIFO.
  - Flush clears both entries.
  - Latency is still 1 cycle when skid is empty.

## Test plan
- Reset mid-operation: assert reset_i asynchronously while out_valid_o=1 and ctrl=7'h7F -> all outputs 0 immediately, before the next clock edge.
- Streaming: out_ready_i=1, 4 entries with rd_i=1..4 on consecutive cycles -> rd_o=1..4 on the following 4 cycles, no bubbles, stall_cnt_o=0.
- Stall: hold out_ready_i=0 for 3 cycles with rd=9 held -> rd_o=9 throughout.
  - Without skid: in_ready_o=0.
  - With PIPE_SKID_EN: one more entry (rd=10) is accepted, then in_ready_o=0.
  - On release, rd_o=9 then rd_o=10.
  - stall_cnt_o=3.
- Flush against load: flush_i=1 and in_valid_i=1 in the same cycle, ctrl_i=7'h01 -> next cycle out_valid_o=0, ctrl_o=0, rd_o=0, data_o unchanged.
- Counter saturation: CNT_W=4, hold stall for 20 cycles -> stall_cnt_o=15, then a flush leaves it at 15.
- Bubble squash: in_valid_i=0 with ctrl_i=7'h7F -> ctrl_o stays 0.

Source files
------------

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM elastic pipeline register with valid/ready handshake, flush-to-bubble and stall counter.
// Define PIPE_SKID_EN to add a skid entry and register in_ready_o, removing the out_ready_i -> in_ready_o path.
module ex_mem_pipe_stage #(
    parameter int CTRL_W  = 7,
    parameter int DATA_W  = 32,
    parameter int N_LANES = 5,
    parameter int RD_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [CTRL_W-1:0]         ctrl_i,
    input  logic [N_LANES*DATA_W-1:0] data_i,
    input  logic [RD_W-1:0]           rd_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [CTRL_W-1:0]         ctrl_o,
    output logic [N_LANES*DATA_W-1:0] data_o,
    output logic [RD_W-1:0]           rd_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    logic                      main_valid;
    logic [CTRL_W-1:0]         main_ctrl;
    logic [N_LANES*DATA_W-1:0] main_data;
    logic [RD_W-1:0]           main_rd;
    logic [CNT_W-1:0]          stall_cnt;
    logic                      ready;
    logic                      in_xfer;
    logic                      out_xfer;

    assign in_xfer  = in_valid_i & ready;
    assign out_xfer = main_valid & out_ready_i;

`ifdef PIPE_SKID_EN
    logic                      skid_valid;
    logic [CTRL_W-1:0]         skid_ctrl;
    logic [N_LANES*DATA_W-1:0] skid_data;
    logic [RD_W-1:0]           skid_rd;

    // Ready depends only on the skid flag, so it is a flop output.
    assign ready = !skid_valid;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_rd    <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_rd    <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer) begin
            if (skid_valid) begin
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                main_rd    <= skid_rd;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_ctrl <= ctrl_i;
                main_data <= data_i;
                main_rd   <= rd_i;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (main_valid) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= ctrl_i;
                skid_data  <= data_i;
                skid_rd    <= rd_i;
            end else begin
                main_valid <= 1'b1;
                main_ctrl  <= ctrl_i;
                main_data  <= data_i;
                main_rd    <= rd_i;
            end
        end
    end
`else
    assign ready = !main_valid | out_ready_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_rd    <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
        end else if (in_xfer) begin
            main_valid <= 1'b1;
            main_ctrl  <= ctrl_i;
            main_data  <= data_i;
            main_rd    <= rd_i;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready_i && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Bubbles present zero control and rd so nothing downstream commits.
    assign in_ready_o  = ready;
    assign out_valid_o = main_valid;
    assign ctrl_o      = main_valid ? main_ctrl : '0;
    assign rd_o        = main_valid ? main_rd : '0;
    assign data_o      = main_data;
    assign stall_cnt_o = stall_cnt;

endmodule
